// File: rtl/hazard_unit_id.sv
// hazard_unit_id: ID-stage stall/bubble generator with EX/MEM shadow pipeline
// Ports:
//   clk, reset          rising-edge clock, async active-high reset
//   id_valid            ID holds a real instruction
//   rs_id, rt_id        ID source registers, qualified by uses_rs_id/uses_rt_id
//   branch_id           ID instruction resolves in ID and needs operands now
//   rd_id, reg_write_id, mem_read_id  destination info of the ID instruction
//   stall_id, bubble_ex hold IF/ID and PC, load a NOP into ID/EX
//   rd_ex_m, reg_write_ex_m  MEM-stage destination for the forwarding unit
//   stall_count         saturating count of stalled cycles
module hazard_unit_id #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             id_valid,
    input  logic [4:0]       rs_id,
    input  logic [4:0]       rt_id,
    input  logic             uses_rs_id,
    input  logic             uses_rt_id,
    input  logic             branch_id,
    input  logic [4:0]       rd_id,
    input  logic             reg_write_id,
    input  logic             mem_read_id,
    output logic             stall_id,
    output logic             bubble_ex,
    output logic [4:0]       rd_ex_m,
    output logic             reg_write_ex_m,
    output logic [CNT_W-1:0] stall_count
);
    logic [4:0]       ex_rd_q, ex_rd_d, mem_rd_q;
    logic             ex_wr_q, ex_wr_d, ex_ld_q, ex_ld_d, mem_wr_q, mem_ld_q;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             ex_match, mem_match, load_use, br_ex, br_mem_ld, stall;

    // r0 is hardwired zero, so it never carries a dependency
    assign ex_match  = (ex_rd_q != 5'd0) &&
                       ((uses_rs_id && ex_rd_q == rs_id) || (uses_rt_id && ex_rd_q == rt_id));
    assign mem_match = (mem_rd_q != 5'd0) &&
                       ((uses_rs_id && mem_rd_q == rs_id) || (uses_rt_id && mem_rd_q == rt_id));

    assign load_use  = id_valid && ex_ld_q && ex_wr_q && ex_match;
    assign br_ex     = id_valid && branch_id && ex_wr_q && ex_match;
    // load data in MEM is only forwardable from WB, too late for an ID branch
    assign br_mem_ld = id_valid && branch_id && mem_ld_q && mem_wr_q && mem_match;
    assign stall     = load_use || br_ex || br_mem_ld;

    assign stall_id       = stall;
    assign bubble_ex      = stall;
    assign rd_ex_m        = mem_rd_q;
    assign reg_write_ex_m = mem_wr_q && !mem_ld_q;
    assign stall_count    = cnt_q;

    always_comb begin
        ex_rd_d = (stall || !id_valid) ? 5'd0 : rd_id;
        ex_wr_d = (stall || !id_valid) ? 1'b0 : reg_write_id;
        ex_ld_d = (stall || !id_valid) ? 1'b0 : mem_read_id;
        cnt_d   = (stall && cnt_q != {CNT_W{1'b1}}) ? cnt_q + CNT_W'(1) : cnt_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ex_rd_q  <= 5'd0;
            ex_wr_q  <= 1'b0;
            ex_ld_q  <= 1'b0;
            mem_rd_q <= 5'd0;
            mem_wr_q <= 1'b0;
            mem_ld_q <= 1'b0;
            cnt_q    <= '0;
        end else begin
            mem_rd_q <= ex_rd_q;
            mem_wr_q <= ex_wr_q;
            mem_ld_q <= ex_ld_q;
            ex_rd_q  <= ex_rd_d;
            ex_wr_q  <= ex_wr_d;
            ex_ld_q  <= ex_ld_d;
            cnt_q    <= cnt_d;
        end
    end
endmodule

// File: tb/tb_hazard_unit_id.sv
// tb_hazard_unit_id: scoreboard bench for hazard_unit_id (default and 4-bit counter instances)
module tb_hazard_unit_id;
    logic        clk = 1'b0;
    logic        reset;
    logic        id_valid, uses_rs_id, uses_rt_id, branch_id, reg_write_id, mem_read_id;
    logic [4:0]  rs_id, rt_id, rd_id;
    logic        stall_id, bubble_ex, reg_write_ex_m;
    logic [4:0]  rd_ex_m;
    logic [15:0] stall_count;
    logic        s_stall, s_bub, s_wr;
    logic [4:0]  s_rd;
    logic [3:0]  s_cnt;
    int          n_chk = 0;
    int          n_err = 0;

    typedef struct {
        string      tag;
        logic       stall;
        logic [4:0] rdm;
        logic       wrm;
        int         cnt;
    } exp_t;
    exp_t sb[$];

    always #5 clk = ~clk;

    hazard_unit_id dut (
        .clk(clk), .reset(reset), .id_valid(id_valid), .rs_id(rs_id), .rt_id(rt_id),
        .uses_rs_id(uses_rs_id), .uses_rt_id(uses_rt_id), .branch_id(branch_id),
        .rd_id(rd_id), .reg_write_id(reg_write_id), .mem_read_id(mem_read_id),
        .stall_id(stall_id), .bubble_ex(bubble_ex), .rd_ex_m(rd_ex_m),
        .reg_write_ex_m(reg_write_ex_m), .stall_count(stall_count)
    );

    hazard_unit_id #(.CNT_W(4)) dut_sat (
        .clk(clk), .reset(reset), .id_valid(id_valid), .rs_id(rs_id), .rt_id(rt_id),
        .uses_rs_id(uses_rs_id), .uses_rt_id(uses_rt_id), .branch_id(branch_id),
        .rd_id(rd_id), .reg_write_id(reg_write_id), .mem_read_id(mem_read_id),
        .stall_id(s_stall), .bubble_ex(s_bub), .rd_ex_m(s_rd),
        .reg_write_ex_m(s_wr), .stall_count(s_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                         input logic urs, input logic urt, input logic br,
                         input logic [4:0] rd, input logic rw, input logic mr);
        id_valid = v; rs_id = rs; rt_id = rt; uses_rs_id = urs; uses_rt_id = urt;
        branch_id = br; rd_id = rd; reg_write_id = rw; mem_read_id = mr;
    endtask

    // drive one ID instruction for a cycle, queue its expected outputs, compare at negedge
    task automatic cyc(input string tag, input logic v, input logic [4:0] rs, input logic [4:0] rt,
                       input logic urs, input logic urt, input logic br,
                       input logic [4:0] rd, input logic rw, input logic mr,
                       input logic es, input logic [4:0] erd, input logic ewr, input int ecnt);
        exp_t e;
        drive(v, rs, rt, urs, urt, br, rd, rw, mr);
        sb.push_back('{tag, es, erd, ewr, ecnt});
        @(negedge clk);
        e = sb.pop_front();
        chk({e.tag, "_stall"}, 32'(stall_id), 32'(e.stall));
        chk({e.tag, "_bubble"}, 32'(bubble_ex), 32'(e.stall));
        chk({e.tag, "_rdm"}, 32'(rd_ex_m), 32'(e.rdm));
        chk({e.tag, "_wrm"}, 32'(reg_write_ex_m), 32'(e.wrm));
        chk({e.tag, "_cnt"}, 32'(stall_count), 32'(e.cnt));
        chk({e.tag, "_sstall"}, 32'(s_stall), 32'(e.stall));
        chk({e.tag, "_scnt"}, 32'(s_cnt), 32'(e.cnt > 15 ? 15 : e.cnt));
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        chk("rst_stall", 32'(stall_id), 0);
        chk("rst_rdm", 32'(rd_ex_m), 0);
        chk("rst_wrm", 32'(reg_write_ex_m), 0);
        chk("rst_cnt", 32'(stall_count), 0);
        @(posedge clk);
        #1 reset = 1'b0;
        // load-use: lw r5 ; add r6,r5,r1
        cyc("lu_lw",  1, 0, 0, 0, 0, 0, 5, 1, 1, 0, 0, 0, 0);
        cyc("lu_st",  1, 5, 1, 1, 1, 0, 6, 1, 0, 1, 0, 0, 0);
        cyc("lu_go",  1, 5, 1, 1, 1, 0, 6, 1, 0, 0, 5, 0, 1);
        // ALU to branch: add r3 ; beq r3,r4
        cyc("ab_add", 1, 1, 2, 1, 1, 0, 3, 1, 0, 0, 0, 0, 1);
        cyc("ab_st",  1, 3, 4, 1, 1, 1, 0, 0, 0, 1, 6, 1, 1);
        cyc("ab_go",  1, 3, 4, 1, 1, 1, 0, 0, 0, 0, 3, 1, 2);
        // load to branch back-to-back: two stall cycles
        cyc("lb_lw",  1, 0, 0, 0, 0, 0, 7, 1, 1, 0, 0, 0, 2);
        cyc("lb_st1", 1, 7, 0, 1, 1, 1, 0, 0, 0, 1, 0, 0, 2);
        cyc("lb_st2", 1, 7, 0, 1, 1, 1, 0, 0, 0, 1, 7, 0, 3);
        cyc("lb_go",  1, 7, 0, 1, 1, 1, 0, 0, 0, 0, 0, 0, 4);
        // register 0 and unused operands never stall
        cyc("r0_lw",  1, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 4);
        cyc("r0_add", 1, 0, 0, 1, 1, 0, 1, 1, 0, 0, 0, 0, 4);
        cyc("nu_lw",  1, 0, 0, 0, 0, 0, 9, 1, 1, 0, 0, 0, 4);
        cyc("nu_br",  1, 9, 9, 0, 0, 1, 2, 1, 0, 0, 1, 1, 4);
        // load decoded without reg_write never stalls
        cyc("nw_lw",  1, 0, 0, 0, 0, 0, 10, 0, 1, 0, 9, 0, 4);
        cyc("nw_br1", 1, 10, 0, 1, 0, 1, 0, 0, 0, 0, 2, 1, 4);
        cyc("nw_br2", 1, 10, 0, 1, 0, 1, 0, 0, 0, 0, 10, 0, 4);
        // squash: id_valid low with a hazard present, EX must take a bubble
        cyc("sq_lw",  1, 0, 0, 0, 0, 0, 5, 1, 1, 0, 0, 0, 4);
        cyc("sq_drop", 0, 5, 0, 1, 0, 0, 8, 1, 0, 0, 0, 0, 4);
        cyc("sq_br",  1, 8, 0, 1, 0, 1, 0, 0, 0, 0, 5, 0, 4);
        // rs and rt both hazarded: single stall, single count
        cyc("dd_lw",  1, 0, 0, 0, 0, 0, 4, 1, 1, 0, 0, 0, 4);
        cyc("dd_st",  1, 4, 4, 1, 1, 0, 11, 1, 0, 1, 0, 0, 4);
        cyc("dd_go",  1, 4, 4, 1, 1, 0, 11, 1, 0, 0, 4, 0, 5);
        // EX (ALU) and MEM (load) both match a branch
        cyc("em_lw",  1, 0, 0, 0, 0, 0, 12, 1, 1, 0, 0, 0, 5);
        cyc("em_add", 1, 1, 2, 1, 1, 0, 13, 1, 0, 0, 11, 1, 5);
        cyc("em_st",  1, 12, 13, 1, 1, 1, 0, 0, 0, 1, 12, 0, 5);
        cyc("em_go",  1, 12, 13, 1, 1, 1, 0, 0, 0, 0, 13, 1, 6);
        // async reset in the middle of a load-use stall
        cyc("ar_lw",  1, 0, 0, 0, 0, 0, 5, 1, 1, 0, 0, 0, 6);
        drive(1, 5, 1, 1, 1, 0, 6, 1, 0);
        #2 chk("ar_pre_stall", 32'(stall_id), 1);
        reset = 1'b1;
        #1;
        chk("ar_stall", 32'(stall_id), 0);
        chk("ar_bubble", 32'(bubble_ex), 0);
        chk("ar_rdm", 32'(rd_ex_m), 0);
        chk("ar_wrm", 32'(reg_write_ex_m), 0);
        chk("ar_cnt", 32'(stall_count), 0);
        @(posedge clk);
        #1 reset = 1'b0;
        cyc("ar_post", 1, 5, 1, 1, 1, 0, 6, 1, 0, 0, 0, 0, 0);
        // repeated load-use pairs drive the 4-bit counter into saturation
        for (int i = 0; i < 20; i++) begin
            cyc("sat_lw", 1, 0, 0, 0, 0, 0, 5, 1, 1, 0, (i == 0) ? 5'd0 : 5'd5, 0, i);
            cyc("sat_st", 1, 5, 1, 1, 1, 0, 6, 1, 0, 1, (i == 0) ? 5'd6 : 5'd0, (i == 0), i);
        end
        cyc("sat_end", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 5, 0, 20);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
